pid_mul_arbiter: RTL and testbench
==================================

Name: pid_mul_arbiter

Overview:
- Shares one pipelined signed W×W multiplier among NREQ requesters in the PID/plant sequencing datapath (gain products, plant coefficient products).
- Round-robin arbitration, at most one grant per cycle; each result returns with a one-hot tag after a fixed latency.
- Lets the loop FSM and plant model use one multiplier instead of five dedicated ones.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand and result width (signed two's complement).
- MUL_LAT, 2, cycles from grant edge to result valid (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester operation request; level, held until granted.
- op_a  in  NREQ*W  packed operand A; slice i belongs to requester i.
- op_b  in  NREQ*W  packed operand B; slice i belongs to requester i.
- flush  in  1  synchronous; kills all in-flight operations.
- gnt  out  NREQ  one-hot grant, combinational from req and pointer; operands captured at that clk edge.
- res  out  W  product result, registered.
- res_valid  out  NREQ  one-hot owner tag of res, registered; all-zero when no result.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (rst=0, async): rr pointer=0, all pipeline valid/tag stages=0, res=0, res_valid=0, busy=0. gnt=0 while rst=0.
- Arbitration: search req starting at pointer, wrapping mod NREQ. First set bit gets gnt. No req means gnt=0 and the pointer is held.
- Pointer update on a grant to i: pointer <= (i+1) mod NREQ. Loser requests stay pending. No starvation: worst-case wait is NREQ-1 grants.
- Handshake: requester holds req, op_a and op_b stable until it sees gnt high at a clk edge. Keeping req high after a grant means a new operation, which is eligible again per round-robin.
- Throughput: one grant per cycle, fully pipelined, no backpressure. A requester must accept res in the cycle res_valid is set.
- Latency: operation granted at edge k produces res and res_valid at edge k+MUL_LAT, as a one-cycle pulse.
- Arithmetic: full 2W signed product. Default result is the low W bits (wrap), matching the existing in-loop multiply semantics.
- flush=1: gnt forced to 0, all stage valids cleared at the next edge, res_valid=0 next cycle. The pointer is unchanged. flush wins over simultaneous req.
- busy = OR of all stage valids, including the output stage.
- Reset mid-operation: in-flight results are discarded and never appear after rst releases.
- NREQ=1: the pointer is a constant 0 and arbitration reduces to gnt=req.

Optional Feature:
- Macro PID_MUL_SAT_EN.
- Defined: the 2W product saturates to W-bit signed range, giving 0x7FFFFFFF or 0x80000000 for W=32. One extra output bit `sat` (1-bit, registered, aligned with res_valid) flags clamping. Latency is unchanged; saturation folds into the last pipe stage.
- Undefined: low-W-bit wrap; the `sat` port is absent.

Decomposition:
- Shared package pid_pkg holds:
  - data width constant PID_W=32;
  - saturation limits PID_MAX/PID_MIN;
  - default MUL_LAT;
  - function rr_pick(req, ptr) returning a one-hot grant (shared with future arbiters).
- One sub-module pid_mul_pipe: MUL_LAT-stage signed multiplier that carries a valid and an NREQ-bit tag alongside the data, with a flush input and optional saturation.
- The arbiter top holds the pointer, the grant logic and the operand mux.

Test Plan:
- Single op: req=0001, op_a[0]=3, op_b[0]=-4 -> gnt=0001 at edge k; res=0xFFFFFFF4 (-12), res_valid=0001 at edge k+2; busy high edges k..k+2.
- Round-robin: req=1111 held 8 cycles with distinct operands -> gnt sequence 0001,0010,0100,1000,0001,...; each result tag matches its grant 2 cycles earlier.
- Fairness after idle: pointer=2, req=0011 -> gnt=0001 first then 0010; pointer ends at 2.
- Overflow: op_a=0x40000000, op_b=4 -> res=0x00000000 without macro; with PID_MUL_SAT_EN res=0x7FFFFFFF, sat=1. op_a=0x80000000, op_b=2 -> sat gives 0x80000000, sat=1.
- Flush: grants at edges k and k+1, flush=1 at k+1 with req pending -> gnt=0 that cycle, no res_valid at k+2 or k+3, busy=0 at k+2.
- Async reset: rst=0 mid-cycle with 2 ops in flight -> res_valid, busy and res cleared immediately; after release no stale result appears and the first grant goes to requester 0.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared constants and helpers for the PID/plant sequencing datapath.
//   PID_W        default data width
//   PID_MAX/MIN  signed saturation limits for PID_W
//   PID_MUL_LAT  default shared-multiplier latency
//   rr_pick()    round-robin one-hot pick over up to RR_MAXN requesters
package pid_pkg;

  localparam int PID_W       = 32;
  localparam logic [PID_W-1:0] PID_MAX = 32'h7FFF_FFFF;
  localparam logic [PID_W-1:0] PID_MIN = 32'h8000_0000;
  localparam int PID_MUL_LAT = 2;
  localparam int RR_MAXN     = 8;

  // Search req starting at ptr, wrapping modulo n; the first set bit wins.
  // Bits at or above n are ignored. Returns all-zero when nothing is requested.
  function automatic logic [RR_MAXN-1:0] rr_pick(input logic [RR_MAXN-1:0] req,
                                                 input int ptr, input int n);
    logic [RR_MAXN-1:0] g;
    logic               found;
    logic [2:0]         idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAXN; k++) begin
      idx = 3'((ptr + k) % n);
      if ((k < n) && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pid_mul_pipe.sv
// pid_mul_pipe: pipelined signed W x W multiplier carrying a valid bit and an
// NTAG-bit owner tag alongside the data.
//   Stage 0 captures operands at the grant edge; MUL_LAT further register stages
//   follow, the last one being the output register. A result therefore appears
//   MUL_LAT edges after the operands were captured.
// Ports:
//   clk, rst (async, active-low), flush (sync, clears every stage valid)
//   in_valid/in_tag/in_a/in_b : operation entering at this edge
//   res/res_valid             : registered result and one-hot owner tag
//   busy                      : any stage (including output) holds a valid op
//   sat                       : result was clamped (only with PID_MUL_SAT_EN)
// Config: PID_MUL_SAT_EN defined -> saturate the 2W product to W-bit signed
//         range in the output stage; undefined -> keep the low W bits (wrap).
module pid_mul_pipe
  import pid_pkg::*;
#(
  parameter int NTAG    = 4,
  parameter int W       = PID_W,
  parameter int MUL_LAT = PID_MUL_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [NTAG-1:0] in_tag,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  output logic [W-1:0]    res,
  output logic [NTAG-1:0] res_valid,
`ifdef PID_MUL_SAT_EN
  output logic            sat,
`endif
  output logic            busy
);

  // Operand capture stage
  logic            s0_v;
  logic [NTAG-1:0] s0_t;
  logic [W-1:0]    s0_a, s0_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_v <= 1'b0;
      s0_t <= '0;
      s0_a <= '0;
      s0_b <= '0;
    end else begin
      s0_v <= in_valid & ~flush;
      s0_t <= in_tag;
      if (in_valid) begin
        s0_a <= in_a;
        s0_b <= in_b;
      end
    end
  end

  // Sign-extending both operands to 2W makes the low 2W bits of the unsigned
  // product equal to the exact signed product.
  logic [2*W-1:0] prod;
  assign prod = {{W{s0_a[W-1]}}, s0_a} * {{W{s0_b[W-1]}}, s0_b};

  logic [2*W-1:0]  last_p;
  logic            last_v;
  logic [NTAG-1:0] last_t;
  logic            mid_busy;

  generate
    if (MUL_LAT == 1) begin : g_direct
      assign last_p   = prod;
      assign last_v   = s0_v;
      assign last_t   = s0_t;
      assign mid_busy = 1'b0;
    end else begin : g_pipe
      logic [2*W-1:0]  p_q [MUL_LAT-1];
      logic            v_q [MUL_LAT-1];
      logic [NTAG-1:0] t_q [MUL_LAT-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < MUL_LAT-1; i++) begin
            p_q[i] <= '0;
            v_q[i] <= 1'b0;
            t_q[i] <= '0;
          end
        end else begin
          p_q[0] <= prod;
          v_q[0] <= s0_v & ~flush;
          t_q[0] <= s0_t;
          for (int i = 1; i < MUL_LAT-1; i++) begin
            p_q[i] <= p_q[i-1];
            v_q[i] <= v_q[i-1] & ~flush;
            t_q[i] <= t_q[i-1];
          end
        end
      end

      always_comb begin
        mid_busy = 1'b0;
        for (int i = 0; i < MUL_LAT-1; i++) mid_busy = mid_busy | v_q[i];
      end

      assign last_p = p_q[MUL_LAT-2];
      assign last_v = v_q[MUL_LAT-2];
      assign last_t = t_q[MUL_LAT-2];
    end
  endgenerate

  // Output stage: wrap or saturate, then register.
  logic [W-1:0] res_d;
  logic         sat_d;

`ifdef PID_MUL_SAT_EN
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  // The product fits in W signed bits only if bits [2W-1:W-1] all match.
  always_comb begin
    sat_d = ~((&last_p[2*W-1:W-1]) | ~(|last_p[2*W-1:W-1]));
    res_d = sat_d ? (last_p[2*W-1] ? SMIN : SMAX) : last_p[W-1:0];
  end
`else
  logic hi_unused;
  assign hi_unused = ^last_p[2*W-1:W];
  assign res_d     = last_p[W-1:0];
  assign sat_d     = 1'b0;
`endif

  logic sat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res       <= '0;
      res_valid <= '0;
      sat_q     <= 1'b0;
    end else begin
      if (last_v && !flush) res <= res_d;
      res_valid <= (last_v && !flush) ? last_t : '0;
      sat_q     <= last_v & ~flush & sat_d;
    end
  end

`ifdef PID_MUL_SAT_EN
  assign sat = sat_q;
`else
  logic sat_unused;
  assign sat_unused = sat_q;
`endif

  assign busy = s0_v | mid_busy | (|res_valid);

endmodule

// File: rtl/pid_mul_arbiter.sv
// pid_mul_arbiter: shares one pipelined signed multiplier among NREQ requesters
// with round-robin arbitration (one grant per cycle, no backpressure).
// Handshake: a requester holds req, op_a and op_b stable until gnt is high at a
// clk edge; the operands are captured at that edge. Holding req after the grant
// edge requests a new operation. The result returns MUL_LAT edges after the
// grant edge as a one-cycle res_valid pulse tagged one-hot with the owner; the
// owner must take it that cycle.
// Ports:
//   clk, rst (async, active-low), flush (sync, kills all in-flight ops)
//   req[NREQ], op_a/op_b[NREQ*W] (slice i belongs to requester i)
//   gnt[NREQ]   combinational one-hot grant (zero during reset or flush)
//   res[W], res_valid[NREQ] registered result and owner tag; busy
//   sat         clamp flag aligned with res_valid (only with PID_MUL_SAT_EN)
// Config: PID_MUL_SAT_EN selects saturating instead of wrapping results.
module pid_mul_arbiter
  import pid_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = PID_W,
  parameter int MUL_LAT = PID_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic              flush,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      res,
  output logic [NREQ-1:0]   res_valid,
`ifdef PID_MUL_SAT_EN
  output logic              sat,
`endif
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      ptr_nxt;
  logic [RR_MAXN-1:0] req_ext;
  logic [RR_MAXN-1:0] pick;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end

  assign pick = rr_pick(req_ext, int'(ptr), NREQ);

  generate
    if (NREQ < RR_MAXN) begin : g_pad
      logic pick_unused;
      assign pick_unused = |pick[RR_MAXN-1:NREQ];
    end
  endgenerate

  // flush wins over any pending request; nothing is granted while in reset.
  assign gnt = (!rst || flush) ? '0 : pick[NREQ-1:0];

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
    ptr_nxt = (int'(gidx) == NREQ-1) ? '0 : gidx + PW'(1);
  end

  // Pointer moves past the winner; held when idle or flushing (gnt is zero).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ptr <= '0;
    else if (|gnt) ptr <= ptr_nxt;
  end

  logic [W-1:0] mux_a, mux_b;

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mux_a = op_a[i*W +: W];
        mux_b = op_b[i*W +: W];
      end
    end
  end

  pid_mul_pipe #(
    .NTAG    (NREQ),
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (|gnt),
    .in_tag    (gnt),
    .in_a      (mux_a),
    .in_b      (mux_b),
    .res       (res),
    .res_valid (res_valid),
`ifdef PID_MUL_SAT_EN
    .sat       (sat),
`endif
    .busy      (busy)
  );

endmodule

// File: tb/tb_pid_mul_arbiter.sv
// tb_pid_mul_arbiter: directed scenarios plus randomized traffic for
// pid_mul_arbiter (NREQ=4, W=32, MUL_LAT=2), checked every cycle against a
// queue-based model of grants and scheduled results.
module tb_pid_mul_arbiter;
  import pid_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a, op_b;
  logic              flush;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      res;
  logic [NREQ-1:0]   res_valid;
  logic              busy;
`ifdef PID_MUL_SAT_EN
  logic              sat;
`endif

  always #5 clk = ~clk;

  pid_mul_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .gnt       (gnt),
    .res       (res),
    .res_valid (res_valid),
`ifdef PID_MUL_SAT_EN
    .sat       (sat),
`endif
    .busy      (busy)
  );

  // ---------------- model state ----------------
  typedef struct {
    int              due;
    logic [NREQ-1:0] tag;
    logic [W-1:0]    val;
    logic            clamp;
  } ent_t;

  ent_t            exp_q[$];
  int              mptr;
  int              cyc;
  int              n_vec;
  int              n_err;
  logic [NREQ-1:0] exp_gnt;
  logic [NREQ-1:0] gnt_s, rv_s;
  logic [W-1:0]    res_s;
  logic            busy_s;
  logic            sat_s;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Round-robin rule: first requester found scanning from the pointer.
  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (rst && !flush) begin
      for (int k = NREQ-1; k >= 0; k--) begin
        if (req[(mptr + k) % NREQ]) g = '0 | (NREQ'(1) << ((mptr + k) % NREQ));
      end
    end
    return g;
  endfunction

  function automatic ent_t model_op(input int idx);
    ent_t  e;
    longint p;
    p = longint'($signed(op_a[idx*W +: W])) * longint'($signed(op_b[idx*W +: W]));
    e.due   = cyc + LAT;
    e.tag   = NREQ'(1) << idx;
    e.clamp = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef PID_MUL_SAT_EN
    e.val   = !e.clamp ? p[W-1:0] : (p < 0 ? PID_MIN : PID_MAX);
`else
    e.val   = p[W-1:0];
`endif
    return e;
  endfunction

  // One clock: check gnt before the edge, advance model, check outputs after.
  task automatic tick();
    int   g;
    ent_t e;
    logic exp_busy;
    logic [NREQ-1:0] exp_rv;
    #1;
    exp_gnt = model_gnt();
    gnt_s   = gnt;
    chk("gnt", 64'(gnt), 64'(exp_gnt));
    @(posedge clk);
    cyc++;
    if (flush) exp_q.delete();
    else if (exp_gnt != '0) begin
      g = 0;
      for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) g = i;
      exp_q.push_back(model_op(g));
      mptr = (g + 1) % NREQ;
    end
    #1;
    exp_busy = (exp_q.size() > 0);
    exp_rv   = '0;
    e.clamp  = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e      = exp_q.pop_front();
      exp_rv = e.tag;
    end
    rv_s   = res_valid;
    res_s  = res;
    busy_s = busy;
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("res_valid", 64'(res_valid), 64'(exp_rv));
    if (exp_rv != '0) chk("res", 64'(res), 64'(e.val));
`ifdef PID_MUL_SAT_EN
    sat_s = sat;
    chk("sat", 64'(sat), 64'(exp_rv != '0 && e.clamp));
`else
    sat_s = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = W'($urandom_range(0, 200)) - W'(100);
      1: v = $urandom;
      2: case ($urandom_range(0, 3))
           0: v = 32'h4000_0000;
           1: v = 32'h8000_0000;
           2: v = 32'h7FFF_FFFF;
           default: v = 32'hFFFF_FFFF;
         endcase
      default: v = W'($urandom_range(0, 65535));
    endcase
    return v;
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [NREQ-1:0] rr_seq [8];

  initial begin
    n_vec = 0; n_err = 0; mptr = 0; cyc = 0;
    req = '0; op_a = '0; op_b = '0; flush = 1'b0;
    rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state, with requests present to show gnt is held low.
    #2 rst = 1'b0;
    req = '1;
    @(negedge clk); #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single op: 3 * -4 from requester 0.
    set_op(0, 32'd3, -32'sd4);
    req = 4'b0001;
    tick();
    chk("single_gnt", 64'(gnt_s), 64'h1);
    chk("single_busy_k", 64'(busy_s), 64'd1);
    req = '0;
    tick();
    chk("single_busy_k1", 64'(busy_s), 64'd1);
    tick();
    chk("single_res", 64'(res_s), 64'hFFFF_FFF4);
    chk("single_tag", 64'(rv_s), 64'h1);
    chk("single_busy_k2", 64'(busy_s), 64'd1);
    tick();
    chk("single_busy_k3", 64'(busy_s), 64'd0);

    // Round-robin with all four requesting; pointer starts at 1 here.
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 5), W'(7 - 3 * i));
    req = '1;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("rr_seq", 64'(gnt_s), 64'(rr_seq[t]));
      for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) set_op(i, W'(100 * t + i), W'(-t - 1));
    end
    req = '0;
    drain(3);

    // Fairness after idle: move pointer to 2, then requesters 0 and 1.
    req = 4'b0010; tick();
    req = '0;      tick();
    set_op(0, 32'd11, 32'd13);
    set_op(1, -32'sd9, 32'd6);
    req = 4'b0011; tick();
    chk("fair_first", 64'(gnt_s), 64'h1);
    req = 4'b0010; tick();
    chk("fair_second", 64'(gnt_s), 64'h2);
    req = '1;      tick();
    chk("fair_ptr2", 64'(gnt_s), 64'h4);
    req = '0;
    drain(3);

    // Overflow cases from requester 3.
    set_op(3, 32'h4000_0000, 32'd4);
    req = 4'b1000; tick();
    req = '0;      tick(); tick();
    chk("ovf_pos_tag", 64'(rv_s), 64'h8);
`ifdef PID_MUL_SAT_EN
    chk("ovf_pos_res", 64'(res_s), 64'h7FFF_FFFF);
    chk("ovf_pos_sat", 64'(sat_s), 64'd1);
`else
    chk("ovf_pos_res", 64'(res_s), 64'h0);
`endif
    set_op(3, 32'h8000_0000, 32'd2);
    req = 4'b1000; tick();
    req = '0;      tick(); tick();
`ifdef PID_MUL_SAT_EN
    chk("ovf_neg_res", 64'(res_s), 64'h8000_0000);
    chk("ovf_neg_sat", 64'(sat_s), 64'd1);
`else
    chk("ovf_neg_res", 64'(res_s), 64'h0);
`endif
    drain(1);

    // Flush: grant at k, flush at k+1 with requester 1 pending.
    set_op(0, 32'd21, 32'd2);
    set_op(1, 32'd17, 32'd3);
    req = 4'b0011; tick();
    req = 4'b0010; flush = 1'b1; tick();
    chk("flush_gnt", 64'(gnt_s), 64'h0);
    chk("flush_busy", 64'(busy_s), 64'd0);
    flush = 1'b0; tick();
    chk("flush_rv_k2", 64'(rv_s), 64'h0);
    req = '0; tick();
    chk("flush_rv_k3", 64'(rv_s), 64'h0);
    drain(3);

    // Async reset with two ops in flight.
    set_op(2, 32'd1000, 32'd1000);
    set_op(3, -32'sd5, 32'd5);
    req = 4'b1100; tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_rv", 64'(res_valid), 64'h0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res", 64'(res), 64'h0);
    chk("arst_gnt", 64'(gnt), 64'h0);
    exp_q.delete();
    mptr = 0;
    req  = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    drain(3);
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 2), W'(i + 3));
    req = '1; tick();
    chk("arst_first_gnt", 64'(gnt_s), 64'h1);
    req = '0;
    drain(3);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_op(i, rand_op(), rand_op());
        end
      end
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (exp_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) set_op(i, rand_op(), rand_op());
          else req[i] = 1'b0;
        end
      end
    end
    flush = 1'b0;
    req   = '0;
    drain(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
